// File: rtl/dmem_timer_responder.sv
// Machine-timer peripheral on the data-memory bus: 64-bit mtime with prescaler,
// 64-bit compare, control and sticky status, answered with zero-latency reads.
module dmem_timer_responder #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'hFF00,
   parameter logic [7:0]            PRESC_RESET = 8'd0
) (
   input  logic                  clk,
   input  logic                  res_n,
   input  logic                  req,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            mem_size,
   input  logic                  zero_ex,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data,
   output logic                  err,
   output logic                  irq
);

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;

   logic [63:0] mtime_q, mtime_d;
   logic [31:0] shadow_hi_q, shadow_hi_d;
   logic [63:0] cmp_q, cmp_d;
   logic        en_q, en_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  prescale_q, prescale_d;
   logic [7:0]  presc_cnt_q, presc_cnt_d;
   logic        pending_q, pending_d;
   logic        irq_q, irq_d;

   logic [2:0]  reg_sel;
   logic        in_window;
   logic        misaligned;
   logic        reserved;
   logic        acc_ok;
   logic        wr_en;
   logic        rd_en;
   logic [3:0]  be;
   logic [31:0] wmask;
   logic [31:0] wdata_lanes;
   logic [31:0] reg_word;
   logic [31:0] ctrl_word;
   logic        hit;
   logic        tick;
   logic        w1c;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        zx);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = word >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: return zx ? {24'd0, b} : {{24{b[7]}}, b};
         SIZE_HALF: return zx ? {16'd0, h} : {{16{h[15]}}, h};
         default:   return word;
      endcase
   endfunction

   // Decode: window, alignment and reserved offsets
   assign reg_sel   = addr[4:2];
   assign in_window = (addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
   assign reserved  = reg_sel[2] & reg_sel[1];

   always_comb begin
      case (mem_size)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = addr[0];
         SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
         default:   misaligned = 1'b1;
      endcase
   end

   assign err    = req & (~in_window | misaligned | reserved);
   assign acc_ok = req & ~err;
   assign wr_en  = acc_ok & wen;
   assign rd_en  = acc_ok & ~wen;

   always_comb begin
      be = 4'b0000;
      case (mem_size)
         SIZE_BYTE: be[addr[1:0]] = 1'b1;
         SIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
   end

   assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

   always_comb begin
      case (mem_size)
         SIZE_BYTE: wdata_lanes = {4{wr_data[7:0]}};
         SIZE_HALF: wdata_lanes = {2{wr_data[15:0]}};
         default:   wdata_lanes = wr_data;
      endcase
   end

   // Read path
   assign ctrl_word = {16'd0, prescale_q, 6'd0, irq_en_q, en_q};

   always_comb begin
      case (reg_sel)
         OFF_MTIME_LO: reg_word = mtime_q[31:0];
         OFF_MTIME_HI: reg_word = shadow_hi_q;
         OFF_CMP_LO:   reg_word = cmp_q[31:0];
         OFF_CMP_HI:   reg_word = cmp_q[63:32];
         OFF_CTRL:     reg_word = ctrl_word;
         OFF_STATUS:   reg_word = {31'd0, pending_q};
         default:      reg_word = 32'd0;
      endcase
   end

   assign rd_data = rd_en ? extend_load(reg_word, mem_size, addr[1:0], zero_ex) : 32'd0;

   // Next-state: counter, stores, snapshot and interrupt
   assign hit  = (mtime_q >= cmp_q);
   assign tick = en_q & (presc_cnt_q == prescale_q);
   assign w1c  = wr_en & (reg_sel == OFF_STATUS) & be[0] & wdata_lanes[0];

   always_comb begin
      mtime_d     = mtime_q;
      presc_cnt_d = presc_cnt_q;
      cmp_d       = cmp_q;
      en_d        = en_q;
      irq_en_d    = irq_en_q;
      prescale_d  = prescale_q;
      shadow_hi_d = shadow_hi_q;

      if (en_q) begin
         if (tick) begin
            presc_cnt_d = 8'd0;
            mtime_d     = mtime_q + 64'd1;
         end else begin
            presc_cnt_d = presc_cnt_q + 8'd1;
         end
      end

      if (wr_en) begin
         case (reg_sel)
            // Timer stores replace the increment outright; no carry between halves
            OFF_MTIME_LO: mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wdata_lanes, wmask)};
            OFF_MTIME_HI: mtime_d = {merge_lanes(mtime_q[63:32], wdata_lanes, wmask), mtime_q[31:0]};
            OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], merge_lanes(cmp_q[31:0], wdata_lanes, wmask)};
            OFF_CMP_HI:   cmp_d   = {merge_lanes(cmp_q[63:32], wdata_lanes, wmask), cmp_q[31:0]};
            OFF_CTRL: begin
               presc_cnt_d = 8'd0;
               if (be[0]) begin
                  en_d     = wdata_lanes[0];
                  irq_en_d = wdata_lanes[1];
               end
               if (be[1]) prescale_d = wdata_lanes[15:8];
            end
            default: ;
         endcase
      end

      if (rd_en && (reg_sel == OFF_MTIME_LO)) shadow_hi_d = mtime_q[63:32];
   end

   assign pending_d = hit | (pending_q & ~w1c);
   assign irq_d     = pending_d & irq_en_q;
   assign irq       = irq_q;

   // State registers
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         mtime_q     <= 64'd0;
         shadow_hi_q <= 32'd0;
         cmp_q       <= {64{1'b1}};
         en_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         prescale_q  <= PRESC_RESET;
         presc_cnt_q <= 8'd0;
         pending_q   <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         shadow_hi_q <= shadow_hi_d;
         cmp_q       <= cmp_d;
         en_q        <= en_d;
         irq_en_q    <= irq_en_d;
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
         pending_q   <= pending_d;
         irq_q       <= irq_d;
      end
   end

endmodule
